// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, 2-bit colour type and colour helpers for the frame-buffer scan-out.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned COLS                    = 160;
    localparam int unsigned ROWS                    = 120;
    localparam int unsigned SCALE_SHIFT             = 2;
    localparam int unsigned BITS_PER_COLOUR_CHANNEL = 2;
    localparam int unsigned ADDR_W                  = 15;
    localparam int unsigned CNT_W                   = 10;
    localparam int unsigned BAR_W                   = H_VISIBLE / 8;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb2_t;

    function automatic logic [7:0] expand2to8(input logic [1:0] c);
        return {4{c}};
    endfunction

    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * BAR_W)) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic rgb2_t bar_colour(input logic [2:0] idx);
        rgb2_t c;
        case (idx)
            3'd0:    c = 6'b11_11_11;
            3'd1:    c = 6'b11_11_00;
            3'd2:    c = 6'b00_11_11;
            3'd3:    c = 6'b00_11_00;
            3'd4:    c = 6'b11_00_11;
            3'd5:    c = 6'b11_00_00;
            3'd6:    c = 6'b00_00_11;
            default: c = 6'b00_00_00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v scan counters and combinational sync/visible flags for the current position.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs_n,
    output logic             o_vs_n,
    output logic             o_visible,
    output logic             o_frame_wrap
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             r_pix_en;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    if (r_v_cnt == V_LAST) r_v_cnt <= '0;
                    else                   r_v_cnt <= r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign o_pix_en     = r_pix_en;
    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_hs_n       = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign o_vs_n       = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign o_visible    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    // Qualified with pix_en so the downstream register sees a single-clock pulse per frame.
    assign o_frame_wrap = r_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/pixel_scanout.sv
// 160x120 frame-buffer read side: 4x upscaled fetch, 2-stage pixel pipe and VGA pin drive.
// Optional colour-bar test pattern with tp_sel input when PIXEL_SCANOUT_TESTPAT_EN is defined.
module pixel_scanout
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter int unsigned ADDR_W    = vga_timing_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [5:0]        rd_data,
`ifdef PIXEL_SCANOUT_TESTPAT_EN
    input  logic              tp_sel,
`endif
    output logic              frame_start,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B
);

    logic              w_pix_en;
    logic [CNT_W-1:0]  w_h_cnt;
    logic [CNT_W-1:0]  w_v_cnt;
    logic              w_hs_n;
    logic              w_vs_n;
    logic              w_visible;
    logic              w_frame_wrap;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    rgb2_t             w_pix;

    logic [ADDR_W-1:0] r_addr;
    logic              r_hs0;
    logic              r_vs0;
    logic              r_vis0;
    logic              r_frame_start;
    logic              r_vga_clk;
    logic              r_hs;
    logic              r_vs;
    logic              r_blank_n;
    logic [7:0]        r_r;
    logic [7:0]        r_g;
    logic [7:0]        r_b;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_clk        (clock),
        .i_rst_n      (resetn),
        .o_pix_en     (w_pix_en),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_hs_n       (w_hs_n),
        .o_vs_n       (w_vs_n),
        .o_visible    (w_visible),
        .o_frame_wrap (w_frame_wrap)
    );

    assign w_row  = ADDR_W'(w_v_cnt >> SCALE_SHIFT);
    assign w_col  = ADDR_W'(w_h_cnt >> SCALE_SHIFT);
    // row*160 as row*128 + row*32 keeps the multiply in plain adders.
    assign w_addr = (w_row << 7) + (w_row << 5) + w_col;

`ifdef PIXEL_SCANOUT_TESTPAT_EN
    logic [2:0] r_bar0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)       r_bar0 <= '0;
        else if (w_pix_en) r_bar0 <= bar_index(w_h_cnt);
    end
`endif

    always_comb begin
        w_pix = rgb2_t'(rd_data);
`ifdef PIXEL_SCANOUT_TESTPAT_EN
        if (tp_sel) w_pix = bar_colour(r_bar0);
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vga_clk     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vga_clk     <= w_pix_en;
            r_frame_start <= w_frame_wrap;
        end
    end

    // Stage 0 on pix_en=1 registers address and flags; stage 1 on pix_en=0 meets the RAM data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_hs0     <= 1'b1;
            r_vs0     <= 1'b1;
            r_vis0    <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else if (w_pix_en) begin
            if (w_visible) r_addr <= w_addr;
            r_hs0  <= w_hs_n;
            r_vs0  <= w_vs_n;
            r_vis0 <= w_visible;
        end else begin
            r_hs      <= r_hs0;
            r_vs      <= r_vs0;
            r_blank_n <= r_vis0;
            r_r       <= r_vis0 ? expand2to8(w_pix.r) : '0;
            r_g       <= r_vis0 ? expand2to8(w_pix.g) : '0;
            r_b       <= r_vis0 ? expand2to8(w_pix.b) : '0;
        end
    end

    assign rd_addr     = r_addr;
    assign frame_start = r_frame_start;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;

endmodule
